// File: rtl/softplus_pkg.sv
// softplus_pkg: shared widths, region breakpoints and intercepts for the piecewise-linear softplus.
package softplus_pkg;
  localparam int DW = 20;
  localparam int FRAC = 15;
  localparam logic signed [DW-1:0] BP0 = 20'shE8000;
  localparam logic signed [DW-1:0] BP1 = 20'shF4000;
  localparam logic signed [DW-1:0] BP2 = 20'shFC000;
  localparam logic signed [DW-1:0] BP3 = 20'sh04000;
  localparam logic signed [DW-1:0] BP4 = 20'sh06000;
  localparam logic signed [DW-1:0] BP5 = 20'sh0C000;
  localparam logic signed [DW-1:0] BP6 = 20'sh16000;
  // intercepts chosen so adjacent segments meet at every breakpoint
  localparam logic signed [DW-1:0] IC1 = 20'sh03000;
  localparam logic signed [DW-1:0] IC2 = 20'sh04800;
  localparam logic signed [DW-1:0] IC3 = 20'sh05800;
  localparam logic signed [DW-1:0] IC4 = 20'sh05000;
  localparam logic signed [DW-1:0] IC5 = 20'sh04400;
  localparam logic signed [DW-1:0] IC6 = 20'sh02C00;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at ptr; ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] ptr;
  logic [NREQ-1:0] mask, hi, pick;
  // requests at or above ptr win first; otherwise wrap to the lowest request
  assign mask = ~((NREQ'(1) << ptr) - NREQ'(1));
  assign hi = req & mask;
  assign pick = |hi ? hi : req;
  assign grant = pick & (~pick + NREQ'(1));
  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) idx = IDW'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance && |grant) ptr <= (idx == IDW'(NREQ-1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/softplus.sv
// softplus: combinational piecewise-linear softplus on signed Q5.15, slopes built from shifts.
module softplus
  import softplus_pkg::*;
(
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y
);
  logic signed [DW-1:0] h1, h2, h3;
  assign h1 = x >>> 1;
  assign h2 = x >>> 2;
  assign h3 = x >>> 3;
  always_comb begin
    y = x < BP0 ? '0 :
        x < BP1 ? h3 + IC1 :
        x < BP2 ? h2 + IC2 :
        x < BP3 ? h1 + IC3 :
        x < BP4 ? h1 + h3 + IC4 :
        x < BP5 ? h1 + h2 + IC5 :
        x < BP6 ? x - h3 + IC6 : x;
  end
endmodule

// File: rtl/softplus_sched.sv
// softplus_sched: round-robin sharing of one softplus unit across NREQ requesters,
// two registered stages with a backpressurable, id-tagged result.
module softplus_sched #(
  parameter int NREQ = 4,
  parameter int DW   = softplus_pkg::DW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic signed [DW-1:0] res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
);
  logic s1_valid, s1_load, s2_load, xfer;
  logic signed [DW-1:0] s1_x, sel_x, sp_y;
  logic [IDW-1:0] s1_id, gidx;
  logic [NREQ-1:0] grant;
  assign s2_load = s1_valid && (!res_valid || res_ready);
  // rst_n gate keeps req_ready low while reset is held
  assign s1_load = rst_n && (!s1_valid || s2_load);
  assign req_ready = grant & {NREQ{s1_load}};
  assign xfer = |(req_valid & req_ready);
  assign busy = s1_valid | res_valid;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .advance(s1_load), .grant(grant), .idx(gidx)
  );
  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel_x = req_data[i*DW +: DW];
  end
  softplus u_sp (.x(s1_x), .y(sp_y));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x <= '0;
      s1_id <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_x <= sel_x;
          s1_id <= gidx;
        end
      end
      if (s2_load) begin
        res_valid <= 1'b1;
        res_data <= sp_y;
        res_id <= s1_id;
      end else if (res_ready) res_valid <= 1'b0;
    end
  end
endmodule

// File: doc/softplus_sched.md
# softplus_sched

Round-robin scheduler that shares one combinational `softplus` unit among NREQ requesters, for example activation lanes of a neuron array. Each requester presents a signed Q5.15 operand with a valid/ready handshake. The block arbitrates fairly, registers the operand, evaluates softplus, and returns the result in a registered, backpressurable output stage tagged with the requester index. Sustained throughput is one operation per cycle.

## Interface
- `NREQ`, default 4: number of requesters, range 2..16.
- `DW`, default 20: operand/result width, signed Q5.15 (1.0 = 20'sh08000).
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NREQ: per-requester operand valid.
- `req_data`, in, NREQ*DW: operands; requester i uses bits [i*DW +: DW].
- `req_ready`, out, NREQ: one-hot or zero; a transfer happens when `req_valid[i] && req_ready[i]`.
- `res_valid`, out, 1: result valid.
- `res_data`, out, DW: softplus(operand), signed Q5.15.
- `res_id`, out, IDW: index of the requester that issued the operand.
- `res_ready`, in, 1: downstream accepts the result.
- `busy`, out, 1: either pipeline stage holds data.

## Operation
Pipeline stages:
- **S1:** `s1_valid`, `s1_x`, `s1_id`.
- **S2:** `res_valid`, `res_data`, `res_id`.

Advance rules:
- `s2_load = s1_valid && (!res_valid || res_ready)`.
- `s1_load = !s1_valid || s2_load`.

Arbitration:
- Round-robin pointer `ptr`, range 0..NREQ-1.
- Grant goes to the first i with `req_valid[i]`, scanning ptr, ptr+1, … modulo NREQ.
- `req_ready[i] = grant[i] && s1_load`.
- `req_ready` never depends on `req_valid[j]` for j ≠ i except through the grant.

Pointer update:
- On a transfer from requester i: ptr ← (i+1) mod NREQ.
- With no transfer, ptr holds, including while stalled.

Datapath:
- `softplus` evaluates `s1_x` combinationally and its output is captured into `res_data` on `s2_load`.
- No extra rounding or saturation; width stays DW throughout.

Output rules:
- While `res_valid && !res_ready`, `res_data` and `res_id` hold stable.
- `res_valid` drops only after a handshake with no new `s2_load`.

Reset (async assert; synchronous to `clk` on deassert):
- `s1_valid`, `res_valid`, `busy` = 0.
- `ptr`, `s1_id`, `res_id` = 0.
- `s1_x`, `res_data` = 20'sh00000.
- `req_ready` = 0 while `rst_n` = 0.
- Reset mid-operation discards all in-flight operands; no result is emitted for them.

Boundary cases:
- All requesters valid: grant sequence is 0,1,2,…,NREQ-1,0 with no starvation.
- A single requester stays valid: it is granted every cycle.
- Both stages full and `res_ready` = 0: `req_ready` = 0 for all requesters. When `res_ready` rises, S2 drains, S1 moves into S2, and a new grant is issued in the same cycle.
- A requester may drop `req_valid` before it is granted; no transfer occurs.

## Timing
- Transfer at edge k: the result is visible on `res_valid`/`res_data` after edge k+2.
- Latency is 2 cycles.
- Back-to-back transfers every cycle while `res_ready` = 1.
- Combinational paths: `req_valid` → `req_ready`, and `res_ready` → `req_ready`.
- No combinational path from inputs to `res_*`.
- `busy = s1_valid | res_valid`.

## Structure
- Shared package `softplus_pkg`:
  - `DW` = 20 and `FRAC` = 15.
  - Region breakpoints: 20'shE8000, F4000, FC000, 04000, 06000, 0C000, 16000.
  - Intercept constants used by `softplus`.
- One natural sub-module: `rr_arbiter`, parameter NREQ. Inputs `req`, `advance`; outputs one-hot `grant`; it holds the pointer.
- The existing `softplus` unit is instantiated unchanged between S1 and S2.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-stream with both stages full. All outputs zero immediately; after release, the first result comes from a new transfer only.
- **Single operation:** requester 2 sends 20'sh08000 (1.0). Two cycles later, `res_valid` = 1, `res_data` = 20'sh0A400, `res_id` = 2.
- **Region coverage:** requester 0 sends 20'shE0000, F8000, 00000, 20000 back-to-back with `res_ready` = 1. Results are 20'sh00000, 02800, 05800, 20000 on consecutive cycles.
- **Fairness:** all four requesters valid continuously for 8 cycles. `res_id` sequence is 0,1,2,3,0,1,2,3.
- **Backpressure:** hold `res_ready` = 0 for 5 cycles with requesters valid. Exactly 2 operands are accepted, `res_data` stays stable, and no operand is lost or duplicated after release.
- **Pointer hold:** requester 3 is granted, then `res_ready` stalls; requester 1 asserts. The next grant goes to 1, because ptr = 0 is held and requester 0 is idle.
